pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_seq_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/pll_reset_sequencer.sv | 148 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// ============================================================================
// pll_seq_pkg : state encoding shared by the PLL reset sequencer and status readers
// Revision    : 1.0
// ============================================================================
`default_nettype none

package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_seq_state_e;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// sync_2ff : two-flop synchroniser for a single asynchronous bit
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
// ============================================================================
// pll_reset_sequencer : PLL reset / lock-qualification / domain-release sequencer
// Revision            : 1.0
// ============================================================================
`default_nettype none

module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned RELEASE_CYCLES      = 64,
  parameter int unsigned MAX_RETRIES         = 4
) (
  input  logic       piul1Clock,
  input  logic       piul1Reset,
  input  logic       piul1Locked,
  input  logic       piul1Restart,
  output logic       poul1PllReset,
  output logic       poul1DomainReset,
  output logic       poul1Ready,
  output logic       poul1Fault,
  output logic [7:0] pouv8LossCount,
  output logic [2:0] pouv3State
);

  localparam int unsigned CNT_MAX = max2(max2(max2(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                              max2(LOCK_TIMEOUT_CYCLES, RELEASE_CYCLES)),
                                         MAX_RETRIES);
  localparam int unsigned CW = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] c_pll_rst     = CW'(PLL_RST_CYCLES);
  localparam logic [CW-1:0] c_stable      = CW'(LOCK_STABLE_CYCLES);
  localparam logic [CW-1:0] c_timeout     = CW'(LOCK_TIMEOUT_CYCLES);
  localparam logic [CW-1:0] c_release     = CW'(RELEASE_CYCLES);
  localparam logic [CW-1:0] c_max_retries = CW'(MAX_RETRIES);

  pll_seq_state_e state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  stable_q, stable_d;
  logic [CW-1:0]  retry_q, retry_d;
  logic [7:0]     loss_q, loss_d;
  logic           pll_rst_q, dom_rst_q, ready_q, fault_q;
  logic           w_lock_s;
  logic [CW-1:0]  w_cnt_inc, w_stable_inc, w_retry_inc;
  logic [7:0]     w_loss_inc;

  sync_2ff u_lock_sync (
    .clk (piul1Clock),
    .rst (piul1Reset),
    .d_i (piul1Locked),
    .q_o (w_lock_s)
  );

  // Increments hold at all-ones so no counter can wrap.
  assign w_cnt_inc    = (cnt_q    == '1) ? cnt_q    : cnt_q    + 1'b1;
  assign w_stable_inc = (stable_q == '1) ? stable_q : stable_q + 1'b1;
  assign w_retry_inc  = (retry_q  == '1) ? retry_q  : retry_q  + 1'b1;
  assign w_loss_inc   = (loss_q == 8'hFF) ? loss_q  : loss_q   + 8'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = w_cnt_inc;
    stable_d = stable_q;
    retry_d  = retry_q;
    loss_d   = loss_q;

    case (state_q)
      ST_PLL_RST: begin
        if (w_cnt_inc == c_pll_rst) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        stable_d = w_lock_s ? w_stable_inc : '0;
        if (w_lock_s && (w_stable_inc == c_stable)) begin
          state_d = ST_RELEASE;
        end else if (w_cnt_inc == c_timeout) begin
          retry_d = w_retry_inc;
          state_d = (w_retry_inc < c_max_retries) ? ST_PLL_RST : ST_FAULT;
        end
      end
      ST_RELEASE: begin
        if (!w_lock_s) begin
          state_d = ST_PLL_RST;
          loss_d  = w_loss_inc;
          retry_d = '0;
        end else if (w_cnt_inc == c_release) begin
          state_d = ST_RUN;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        if (!w_lock_s) begin
          state_d = ST_PLL_RST;
          loss_d  = w_loss_inc;
          retry_d = '0;
        end
      end
      default: state_d = state_q;
    endcase

    // Restart overrides any transition chosen above, including a lock loss.
    if (piul1Restart && (state_q != ST_PLL_RST)) begin
      state_d = ST_PLL_RST;
      retry_d = '0;
      loss_d  = loss_q;
    end

    if (state_d != state_q) begin
      cnt_d    = '0;
      stable_d = '0;
    end
  end

  always_ff @(posedge piul1Clock) begin
    if (piul1Reset) begin
      state_q   <= ST_PLL_RST;
      cnt_q     <= '0;
      stable_q  <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      dom_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
      dom_rst_q <= (state_d != ST_RUN);
      ready_q   <= (state_d == ST_RUN);
      fault_q   <= (state_d == ST_FAULT);
    end
  end

  assign poul1PllReset    = pll_rst_q;
  assign poul1DomainReset = dom_rst_q;
  assign poul1Ready       = ready_q;
  assign poul1Fault       = fault_q;
  assign pouv8LossCount   = loss_q;
  assign pouv3State       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
// ============================================================================
// tb_pll_reset_sequencer : directed self-checking bench for pll_reset_sequencer
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked;
  logic       restart;
  logic       pll_rst;
  logic       dom_rst;
  logic       ready;
  logic       fault;
  logic [7:0] loss;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .RELEASE_CYCLES      (4),
    .MAX_RETRIES         (2)
  ) dut (
    .piul1Clock       (clk),
    .piul1Reset       (rst),
    .piul1Locked      (locked),
    .piul1Restart     (restart),
    .poul1PllReset    (pll_rst),
    .poul1DomainReset (dom_rst),
    .poul1Ready       (ready),
    .poul1Fault       (fault),
    .pouv8LossCount   (loss),
    .pouv3State       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bounded wait; an expired budget is reported as a failed state comparison.
  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    int k = 0;
    while (state !== s && k < budget) begin
      step(1);
      k++;
    end
    if (state !== s) check(tag, 32'(state), 32'(s));
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    restart = 1'b0;
    locked  = 1'b0;
    step(2);
    rst     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_pll"},   32'(pll_rst), 32'd1);
    check({tag, "_dom"},   32'(dom_rst), 32'd1);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_loss"},  32'(loss), 32'd0);
  endtask

  initial begin
    rst = 1'b1; locked = 1'b0; restart = 1'b0;
    step(2);
    check_reset_outputs("rst");
    rst = 1'b0;

    // Clean start: locked rises at edge 10, Ready at 10+2+8+4.
    step(3);
    check("clean_pll_e3", 32'(pll_rst), 32'd1);
    step(1);
    check("clean_pll_e4", 32'(pll_rst), 32'd0);
    check("clean_wait_e4", 32'(state), 32'd1);
    step(6);
    locked = 1'b1;
    step(13);
    check("clean_ready_e23", 32'(ready), 32'd0);
    step(1);
    check("clean_ready_e24", 32'(ready), 32'd1);
    check("clean_run", 32'(state), 32'd3);
    check("clean_dom", 32'(dom_rst), 32'd0);
    check("clean_loss", 32'(loss), 32'd0);

    // Loss in RUN: DomainReset after 2 sync + 1 cycles.
    locked = 1'b0;
    step(2);
    check("loss_dom_e2", 32'(dom_rst), 32'd0);
    step(1);
    check("loss_dom_e3", 32'(dom_rst), 32'd1);
    check("loss_state", 32'(state), 32'd0);
    check("loss_ready", 32'(ready), 32'd0);
    check("loss_count", 32'(loss), 32'd1);
    locked = 1'b1;
    wait_state("relock_run", 3'd3, 100);
    check("relock_ready", 32'(ready), 32'd1);

    // Chattering lock: timeout after 32 WAIT_LOCK cycles.
    do_reset();
    for (int k = 1; k <= 36; k++) begin
      locked = (((k - 1) / 5) % 2) == 1;
      step(1);
      if (k == 35) check("chatter_wait_e35", 32'(state), 32'd1);
      if (k == 36) check("chatter_rst_e36", 32'(state), 32'd0);
    end

    // Stable count completes on the same cycle as the timeout: RELEASE wins.
    do_reset();
    step(26);
    locked = 1'b1;
    step(9);
    check("tie_wait_e35", 32'(state), 32'd1);
    step(1);
    check("tie_release_e36", 32'(state), 32'd2);

    // No lock: two timeouts then FAULT; Restart recovers and clears retries.
    do_reset();
    step(71);
    check("nolock_wait_e71", 32'(state), 32'd1);
    step(1);
    check("nolock_fault_state", 32'(state), 32'd4);
    check("nolock_fault", 32'(fault), 32'd1);
    check("nolock_pll", 32'(pll_rst), 32'd1);
    check("nolock_dom", 32'(dom_rst), 32'd1);
    step(5);
    check("fault_sticky", 32'(state), 32'd4);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check("restart_state", 32'(state), 32'd0);
    check("restart_fault", 32'(fault), 32'd0);
    step(35);
    check("retry_clr_wait", 32'(state), 32'd1);
    step(1);
    check("retry_clr_pllrst", 32'(state), 32'd0);

    // Restart coincident with lock_s falling in RUN: no loss counted.
    do_reset();
    locked = 1'b1;
    wait_state("coinc_run", 3'd3, 100);
    locked = 1'b0;
    step(2);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check("coinc_state", 32'(state), 32'd0);
    check("coinc_loss", 32'(loss), 32'd0);
    locked = 1'b1;

    // Saturation: 260 loss events.
    for (int i = 0; i < 260; i++) begin
      wait_state("sat_run", 3'd3, 100);
      locked = 1'b0;
      wait_state("sat_drop", 3'd0, 10);
      locked = 1'b1;
    end
    check("sat_loss", 32'(loss), 32'd255);

    // Mid-RUN reset.
    wait_state("midrun_run", 3'd3, 100);
    check("midrun_ready", 32'(ready), 32'd1);
    rst = 1'b1;
    step(1);
    check_reset_outputs("midrun");
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
